// File: rtl/ball_motion_pkg.sv
// Shared Pong game definitions: screen and paddle geometry, state encoding,
// direction constants and a paddle/ball vertical overlap helper.
package ball_motion_pkg;

    // Screen and paddle geometry, shared with the renderer and paddle controllers
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int BALL_SIZE  = 8;
    localparam int PADDLE_W   = 8;
    localparam int PADDLE_H   = 64;
    localparam int PADDLE_L_X = 16;
    localparam int PADDLE_R_X = 616;

    // State encoding
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_PLAY   = 2'd1;
    localparam logic [1:0] STATE_SCORED = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = STATE_IDLE,
        PLAY   = STATE_PLAY,
        SCORED = STATE_SCORED
    } state_t;

    // Direction flags: 1 means toward smaller coordinates
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    // Position-width constants
    localparam logic [9:0] X_CENTER = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CENTER = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] X_MAX    = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] Y_MAX    = 10'(V_ACTIVE - BALL_SIZE);

    // 11-bit versions for overflow-free comparisons against sums
    localparam logic [10:0] FACE_L_W = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] FACE_R_W = 11'(PADDLE_R_X - BALL_SIZE);
    localparam logic [10:0] X_MAX_W  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX_W  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] BALL_W   = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_H_W  = 11'(PADDLE_H);

    // True when the ball rows intersect the paddle rows
    function automatic logic overlap(input logic [9:0] ball_y, input logic [9:0] pad_y);
        return (({1'b0, ball_y} + BALL_W) > {1'b0, pad_y}) &&
               ({1'b0, ball_y} < ({1'b0, pad_y} + PAD_H_W));
    endfunction

endpackage

// File: rtl/ball_axis_y.sv
// Combinational vertical step: advance y by v and bounce off the top and
// bottom walls, clamping to the wall on contact.
module ball_axis_y
    import ball_motion_pkg::*;
(
    input  logic [9:0] y,
    input  logic       dir_y,
    input  logic [2:0] v,
    output logic [9:0] y_next,
    output logic       dir_y_next
);

    logic [10:0] y_w;
    logic [10:0] v_w;
    logic [10:0] y_sum;

    assign y_w   = {1'b0, y};
    assign v_w   = {8'b0, v};
    assign y_sum = y_w + v_w;

    // Wall bounce: clamp to the wall and flip direction when the step would reach it
    always_comb begin
        y_next     = y;
        dir_y_next = dir_y;
        if (dir_y == DIR_DOWN) begin
            if (y_sum >= Y_MAX_W) begin
                y_next     = Y_MAX;
                dir_y_next = DIR_UP;
            end else begin
                y_next = y_sum[9:0];
            end
        end else begin
            if (y_w <= v_w) begin
                y_next     = '0;
                dir_y_next = DIR_DOWN;
            end else begin
                y_next = y - {7'b0, v};
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Pong ball kinematics: serve, wall and paddle reflection, miss detection.
// Moves once per frame_tick; publishes registered position and score pulses.
module ball_motion
    import ball_motion_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [2:0] ball_velocity,
    input  logic       serve,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       in_play,
    output logic       score_l,
    output logic       score_r
);

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;
    logic       serve_dir_q, serve_dir_d;
    logic       in_play_q, in_play_d;
    logic       score_l_q, score_l_d;
    logic       score_r_q, score_r_d;

    logic [9:0]  y_step;
    logic        dir_y_step;
    logic [9:0]  x_step;
    logic        dir_x_step;
    logic        miss_left;
    logic        miss_right;
    logic [10:0] x_w, v_w, x_sum, x_diff;

    ball_axis_y u_axis_y (
        .y          (y_q),
        .dir_y      (dir_y_q),
        .v          (ball_velocity),
        .y_next     (y_step),
        .dir_y_next (dir_y_step)
    );

    assign x_w    = {1'b0, x_q};
    assign v_w    = {8'b0, ball_velocity};
    assign x_sum  = x_w + v_w;
    assign x_diff = x_w - v_w;

    // Horizontal step: paddle hit takes priority over miss; a hit requires the
    // ball to start on the near side of the paddle face
    always_comb begin
        x_step     = x_q;
        dir_x_step = dir_x_q;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        if (dir_x_q == DIR_LEFT) begin
            if (x_w >= FACE_L_W && x_diff <= FACE_L_W && overlap(y_q, paddle_l_y)) begin
                x_step     = FACE_L_W[9:0];
                dir_x_step = DIR_RIGHT;
            end else if (x_w <= v_w) begin
                x_step    = '0;
                miss_left = 1'b1;
            end else begin
                x_step = x_diff[9:0];
            end
        end else begin
            if (x_sum >= FACE_R_W && x_w <= FACE_R_W && overlap(y_q, paddle_r_y)) begin
                x_step     = FACE_R_W[9:0];
                dir_x_step = DIR_LEFT;
            end else if (x_sum >= X_MAX_W) begin
                x_step     = X_MAX;
                miss_right = 1'b1;
            end else begin
                x_step = x_sum[9:0];
            end
        end
    end

    // Game FSM: serve launch, per-frame movement, score and recentre
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        serve_dir_d = serve_dir_q;
        score_l_d   = 1'b0;
        score_r_d   = 1'b0;
        case (state_q)
            IDLE: begin
                x_d = X_CENTER;
                y_d = Y_CENTER;
                if (serve && ball_velocity != '0) begin
                    state_d = PLAY;
                    dir_x_d = serve_dir_q;
                    dir_y_d = DIR_DOWN;
                end
            end
            PLAY: begin
                if (frame_tick && ball_velocity != '0) begin
                    x_d     = x_step;
                    y_d     = y_step;
                    dir_x_d = dir_x_step;
                    dir_y_d = dir_y_step;
                    if (miss_left) begin
                        score_r_d   = 1'b1;
                        serve_dir_d = DIR_LEFT;
                        state_d     = SCORED;
                    end else if (miss_right) begin
                        score_l_d   = 1'b1;
                        serve_dir_d = DIR_RIGHT;
                        state_d     = SCORED;
                    end
                end
            end
            SCORED: begin
                if (frame_tick) begin
                    state_d = IDLE;
                    x_d     = X_CENTER;
                    y_d     = Y_CENTER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_play_d = (state_d == PLAY);
    end

    // State and output registers; reset wins over any pending score pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= X_CENTER;
            y_q         <= Y_CENTER;
            dir_x_q     <= DIR_RIGHT;
            dir_y_q     <= DIR_DOWN;
            serve_dir_q <= DIR_RIGHT;
            in_play_q   <= 1'b0;
            score_l_q   <= 1'b0;
            score_r_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            serve_dir_q <= serve_dir_d;
            in_play_q   <= in_play_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
        end
    end

    assign ball_x  = x_q;
    assign ball_y  = y_q;
    assign in_play = in_play_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule

// File: doc/ball_motion.md
# ball_motion

Pong ball kinematics engine; consumes `ball_velocity` from the difficulty selector and advances the ball once per video frame. Handles serve, wall reflection, paddle reflection and miss detection. Publishes the ball position to the pixel renderer and one-cycle score pulses to the scoreboard. Sits between the difficulty selector and paddle controllers upstream, and the VGA renderer and score counter downstream.

## Interface
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in pixels.
- `BALL_SIZE`, 8: ball edge length in pixels (square).
- `PADDLE_W`, 8: paddle width.
- `PADDLE_H`, 64: paddle height.
- `PADDLE_L_X`, 16: left paddle left edge x.
- `PADDLE_R_X`, 616: right paddle left edge x.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame (vsync start); sole movement enable.
- `ball_velocity` in 3: pixels per frame per axis; 0 = paused.
- `serve` in 1: level or pulse; launches the ball from IDLE.
- `paddle_l_y` in 10: left paddle top y.
- `paddle_r_y` in 10: right paddle top y.
- `ball_x` out 10: ball left edge x.
- `ball_y` out 10: ball top edge y.
- `in_play` out 1: high in PLAY state.
- `score_l` out 1: one-cycle pulse, left player scored (right missed).
- `score_r` out 1: one-cycle pulse, right player scored (left missed).

## Operation
- States: IDLE, PLAY, SCORED.
- Reset state:
  - IDLE.
  - `ball_x` = (H_ACTIVE−BALL_SIZE)/2 = 316.
  - `ball_y` = (V_ACTIVE−BALL_SIZE)/2 = 236.
  - dir_x = right, dir_y = down.
  - `in_play` = 0, `score_l` = 0, `score_r` = 0.
  - `serve_dir` = right.
- IDLE:
  - Ball held at center.
  - Transition to PLAY when `serve` = 1 and `ball_velocity` ≠ 0.
  - On that transition, dir_x := `serve_dir`, dir_y := down.
  - `serve` with `ball_velocity` = 0 is ignored.
- PLAY, on each `frame_tick`: sample v = `ball_velocity`. If v = 0, hold position and direction (pause). Otherwise update x and y independently in the same tick.
- Y axis:
  - Down: if y + v ≥ V_ACTIVE−BALL_SIZE, set y := V_ACTIVE−BALL_SIZE and dir_y := up; else y := y + v.
  - Up: if y ≤ v, set y := 0 and dir_y := down; else y := y − v.
- X axis, moving left (face = PADDLE_L_X+PADDLE_W = 24):
  - Hit: x − v ≤ face and x ≥ face and vertical overlap (y+BALL_SIZE > `paddle_l_y` and y < `paddle_l_y`+PADDLE_H). Then x := face, dir_x := right.
  - Miss: else if x ≤ v. Then x := 0, pulse `score_r`, `serve_dir` := left, go to SCORED.
  - Otherwise x := x − v.
- X axis, moving right (face = PADDLE_R_X−BALL_SIZE = 608):
  - Hit: x + v ≥ face and x ≤ face and overlap with `paddle_r_y`. Then x := face, dir_x := left.
  - Miss: else if x + v ≥ H_ACTIVE−BALL_SIZE. Then x := 632, pulse `score_l`, `serve_dir` := right, go to SCORED.
- Overlap comparisons use the paddle y sampled in the same tick.
- Width rules: all sums computed 11 bits wide. No wrap-around permitted; clamps above guarantee 0 ≤ x ≤ 632 and 0 ≤ y ≤ 472.
- SCORED:
  - Ball frozen at the miss position for the rest of the frame.
  - Next `frame_tick` recenters the ball and enters IDLE.
  - `serve` ignored.
- Loser serves: `serve_dir` points toward the player who conceded.

## Timing
- All outputs registered.
- Position updates appear the cycle after `frame_tick` is sampled high.
- `score_l`/`score_r`: high exactly one cycle, coincident with the position update; never both high.
- IDLE→PLAY: `in_play` rises the cycle after `serve` is sampled. If `frame_tick` coincides with serve, no movement occurs on that tick.
- `ball_velocity` changes take effect at the next `frame_tick`; no mid-frame effect.
- `rst` mid-play: next cycle all reset values, including `serve_dir` = right. No score pulse is emitted, even if a miss coincides with `rst`.
- `frame_tick` outside PLAY/SCORED has no effect.

## Structure
- Shared game package holds:
  - State encoding localparams (IDLE=0, PLAY=1, SCORED=2).
  - Direction constants (DIR_LEFT/DIR_UP=1).
  - Screen and paddle geometry defaults, shared with the renderer and paddle controllers.
- One sub-module, `ball_axis_y`: combinational wall-bounce step (y, dir_y, v → next y, next dir_y).
- X-axis paddle/miss logic and the FSM stay in the top.

## Test plan
- Reset then serve with v=2:
  - 316,236 → 318,238 after one tick.
  - `in_play` = 1.
- Top wall, y=1, dir up, v=3: one tick → y=0, dir_y down; next tick y=3.
- Left hit, x=26, dir left, v=4, `paddle_l_y`=200, y=220: → x=24, dir right; next tick x=28, no score.
- Left miss, same but `paddle_l_y`=0, y=400:
  - Steps to 22, then subsequent ticks → x=0, `score_r` one-cycle pulse, SCORED.
  - Next tick → 316,236 in IDLE.
  - Next serve moves left.
- Pause and serve gating:
  - v=0 in PLAY: position constant for 5 ticks.
  - v=0 in IDLE with serve: stays IDLE.
- `rst` asserted on the same cycle as a right miss: no `score_l`, outputs at reset values, `serve_dir` right.
